main_memory_ctrl: RTL and testbench

//  Backing main memory with fixed access latency, sitting directly downstream of the

---
 rtl/main_memory_ctrl_pkg.sv | 13 +
 rtl/main_memory_ctrl_if.sv | 22 ++
 rtl/main_memory_ctrl_byte_array.sv | 38 +++
 rtl/main_memory_ctrl.sv | 88 ++++++++
 tb/tb_main_memory_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/main_memory_ctrl_pkg.sv
// Shared types and constants for the main memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/main_memory_ctrl_if.sv
// Cache-to-memory request/done bus.
interface main_memory_ctrl_if;
  logic        mem_req;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_busy;

  // Cache side issues requests.
  modport master (
    output mem_req, mem_write_en, mem_address, mem_wdata,
    input  mem_rdata, mem_done, mem_busy
  );

  // Memory side serves them.
  modport slave (
    input  mem_req, mem_write_en, mem_address, mem_wdata,
    output mem_rdata, mem_done, mem_busy
  );
endinterface

// File: rtl/main_memory_ctrl_byte_array.sv
// Four byte-lane RAMs indexed by word. Lane k holds byte A+k, which is the
// k-th most significant byte of the big-endian word.
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int WORDS = 2048,
  parameter int IW    = 11
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_we,
  input  logic                           i_re,
  input  logic [IW-1:0]                  i_idx,
  input  logic [WORD_BYTES*BYTE_W-1:0]   i_wdata,
  output logic [WORD_BYTES*BYTE_W-1:0]   o_rdata
);

  for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
    localparam int HI = (WORD_BYTES - k) * BYTE_W - 1;

    logic [BYTE_W-1:0] r_ram [WORDS];
    logic [BYTE_W-1:0] r_rd;

    // Synchronous byte write; contents survive reset.
    always_ff @(posedge i_clk) begin
      if (i_we) r_ram[i_idx] <= i_wdata[HI -: BYTE_W];
    end

    // Registered read, held between reads, cleared by reset.
    always_ff @(posedge i_clk) begin
      if (i_rst)     r_rd <= '0;
      else if (i_re) r_rd <= r_ram[i_idx];
    end

    assign o_rdata[HI -: BYTE_W] = r_rd;
  end

endmodule

// File: rtl/main_memory_ctrl.sv
// Fixed-latency backing memory: one word fill or write-back per request.
// The FSM latches the request in IDLE, counts down in BUSY, performs the
// access on the last BUSY edge and pulses done for one cycle in DONE.
module main_memory_ctrl
  import mem_pkg::*;
#(
  parameter int    MEM_BYTES = 8192,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  main_memory_ctrl_if.slave bus
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int IW    = (AW > 2) ? AW - 2 : 1;
  localparam int WORDS = MEM_BYTES / WORD_BYTES;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic          w_fire, w_mem_we, w_mem_re;
  logic [31:0]   w_rdata;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: DONE always falls back to IDLE, so a request can only be
  // taken one cycle after the done pulse.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.mem_req) w_next = S_BUSY;
      S_BUSY:  if (r_count == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only; array strobes on the
  // final BUSY edge. A reset on that edge drops the write.
  always_comb begin
    w_fire       = (r_state == S_BUSY) && (r_count == '0);
    w_mem_we     = w_fire && r_we && !reset;
    w_mem_re     = w_fire && !r_we;
    bus.mem_done = (r_state == S_DONE);
    bus.mem_busy = (r_state != S_IDLE);
  end

  // Latency counter and request latches; inputs are sampled once per
  // transfer and ignored while busy. Upper address bits wrap silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_state == S_IDLE && bus.mem_req) begin
      r_count <= CNT_INIT;
      r_idx   <= IW'(bus.mem_address >> 2);
      r_wdata <= bus.mem_wdata;
      r_we    <= bus.mem_write_en;
    end else if (r_state == S_BUSY && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  mem_byte_array #(
    .WORDS (WORDS),
    .IW    (IW)
  ) u_array (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign bus.mem_rdata = w_rdata;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboarded bench for main_memory_ctrl: two instances (LATENCY 4 and 1),
// byte-level reference memory, and a per-cycle monitor for done/busy/rdata.
module tb_main_memory_ctrl;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a  [2];
  logic        req_a  [2];
  logic        we_a   [2];
  logic [31:0] addr_a [2];
  logic [31:0] wd_a   [2];
  int          acc_a  [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] pool [6] = '{32'h40, 32'h44, 32'h80, 32'h10, 32'h1FFC, 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_l
    localparam int LAT = (g == 0) ? 4 : 1;
    localparam int MB  = (g == 0) ? 8192 : 256;

    main_memory_ctrl_if bus ();
    assign bus.mem_req      = req_a[g];
    assign bus.mem_write_en = we_a[g];
    assign bus.mem_address  = addr_a[g];
    assign bus.mem_wdata    = wd_a[g];

    main_memory_ctrl #(
      .MEM_BYTES (MB),
      .LATENCY   (LAT),
      .INIT_FILE ("")
    ) u_dut (
      .clk   (clk),
      .reset (rst_a[g]),
      .bus   (bus)
    );

    // Reference: byte memory, edge counter, time of next possible accept.
    exp_t        q[$];
    logic [7:0]  mem [int];
    int          t = 0;
    int          next_free = 0;
    bit          pend_v = 1'b0;
    int          pend_cyc, pend_a;
    logic [31:0] pend_d;
    logic [31:0] exp_rd = 'x;
    bit          armed = 1'b0;

    always @(posedge clk) begin : p_model
      int a;
      logic [31:0] w;
      t++;
      if (rst_a[g]) begin
        q.delete();
        pend_v    = 1'b0;
        next_free = t + 1;
        exp_rd    = 32'h0;
        armed     = 1'b1;
      end else begin
        if (pend_v && t == pend_cyc) begin
          for (int k = 0; k < 4; k++) mem[pend_a + k] = pend_d[31 - 8*k -: 8];
          pend_v = 1'b0;
        end
        if (req_a[g] && t >= next_free) begin
          a = int'(addr_a[g] & 32'(MB - 4));
          // Access lands LAT edges after accept; one DONE cycle plus the
          // return to IDLE before the next request can be taken.
          next_free = t + LAT + 2;
          acc_a[g]++;
          if (we_a[g]) begin
            pend_v   = 1'b1;
            pend_cyc = t + LAT;
            pend_a   = a;
            pend_d   = wd_a[g];
            q.push_back('{t + LAT, 1'b0, 32'h0});
          end else begin
            for (int k = 0; k < 4; k++)
              w[31 - 8*k -: 8] = mem.exists(a + k) ? mem[a + k] : 8'hxx;
            q.push_back('{t + LAT, 1'b1, w});
          end
        end
      end
    end

    always @(negedge clk) begin : p_mon
      exp_t e;
      bit   ed;
      if (armed) begin
        ed = (q.size() != 0) && (q[0].cyc == t);
        chk($sformatf("L%0d done", g), 32'(bus.mem_done), 32'(ed));
        chk($sformatf("L%0d busy", g), 32'(bus.mem_busy), 32'(t <= next_free - 2));
        if (ed) begin
          e = q.pop_front();
          if (e.rd) begin
            if (!$isunknown(e.data)) chk($sformatf("L%0d read data", g), bus.mem_rdata, e.data);
            exp_rd = e.data;
          end
        end else if (q.size() != 0 && q[0].cyc < t) begin
          void'(q.pop_front());
        end
        if (!$isunknown(exp_rd)) chk($sformatf("L%0d rdata hold", g), bus.mem_rdata, exp_rd);
      end
    end
  end

  function automatic logic [31:0] pick0();
    int i;
    i = $urandom_range(5, 0);
    return pool[i] | ($urandom & 32'hFFFF_E000) | ($urandom & 32'h3);
  endfunction

  // Called and returns at a negedge; holds req until the model sees an accept.
  task automatic do_req(input int g, input bit we, input logic [31:0] a, input logic [31:0] d);
    int start, n;
    start = acc_a[g];
    n = 0;
    req_a[g] = 1'b1; we_a[g] = we; addr_a[g] = a; wd_a[g] = d;
    do begin
      @(negedge clk);
      n++;
    end while (acc_a[g] == start && n < 60);
    req_a[g] = 1'b0;
    if (acc_a[g] == start) begin
      checks++;
      failures++;
      $display("FAIL L%0d accept timeout: got no accept expected one within 60 cycles", g);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b1; req_a[i] = 1'b0; we_a[i] = 1'b0;
      addr_a[i] = '0;  wd_a[i] = '0;    acc_a[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Seed every pool word so later reads have known contents.
    foreach (pool[i]) do_req(0, 1'b1, pool[i], $urandom);

    // Write then read back, including an aliased, misaligned address.
    do_req(0, 1'b1, 32'h40, 32'hDEADBEEF);
    do_req(0, 1'b0, 32'h40, 32'h0);
    do_req(0, 1'b0, 32'h2043, 32'h0);

    // Reset in the middle of a write: no done, old data survives.
    do_req(0, 1'b1, 32'h80, 32'h12345678);
    repeat (2) @(negedge clk);
    rst_a[0] = 1'b1;
    @(negedge clk);
    rst_a[0] = 1'b0;
    do_req(0, 1'b0, 32'h80, 32'h0);

    // Request held high with inputs changing every cycle.
    req_a[0] = 1'b1;
    repeat (40) begin
      we_a[0]   = 1'($urandom);
      addr_a[0] = pick0();
      wd_a[0]   = $urandom;
      @(negedge clk);
    end
    req_a[0] = 1'b0;
    repeat (8) @(negedge clk);

    // Random individual transfers.
    repeat (25) do_req(0, 1'($urandom), pick0(), $urandom);

    // LATENCY=1 instance: back-to-back read/write/read with address wrap.
    do_req(1, 1'b1, 32'h10, 32'h0BADF00D);
    do_req(1, 1'b0, 32'h10, 32'h0);
    do_req(1, 1'b1, 32'h110, 32'hCAFE1234);
    do_req(1, 1'b0, 32'h10, 32'h0);

    repeat (10) @(negedge clk);
    chk("L0 drain", 32'(g_l[0].q.size()), 32'h0);
    chk("L1 drain", 32'(g_l[1].q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
